// File: rtl/axi_rd_master_pkg.sv
// axi_rd_master_pkg
// Shared definitions for the AXI read master and its pattern checker.
// Contents:
//   rd_state_t - FSM state encoding
//   AXI_LEN_W  - width of the AXI burst length field
//   ADDR_STEP  - address increment per beat
//   calc_arlen - arlen for the next burst, given the beats still owed
package axi_rd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } rd_state_t;

    localparam int AXI_LEN_W = 8;
    localparam int ADDR_STEP = 2;

    // Clamp the remaining beat count to the burst limit and return it as arlen
    // (beats - 1). The caller never passes remaining = 0.
    function automatic logic [AXI_LEN_W-1:0] calc_arlen(
        input logic [AXI_LEN_W-1:0] remaining,
        input logic [AXI_LEN_W:0]   max_beats
    );
        logic [AXI_LEN_W:0] beats;
        beats = ({1'b0, remaining} > max_beats) ? max_beats : {1'b0, remaining};
        return AXI_LEN_W'(beats - 9'd1);
    endfunction

endpackage

// File: rtl/axi_rd_master_chk.sv
// rd_pattern_chk
// Compares each delivered beat against an incrementing pattern that starts at 1
// and advances by 1 per beat. The first mismatch sets err, which stays set
// until reset. Only built into axi_rd_master when RD_CHECK_EN is defined.
// Ports:
//   clk     - clock
//   rstn    - synchronous active-low reset
//   data_en - beat valid
//   data    - beat value
//   err     - sticky mismatch flag
module rd_pattern_chk #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  data_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] expected;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            expected <= DATA_WIDTH'(1);
            err      <= 1'b0;
        end else if (data_en) begin
            if (data != expected) begin
                err <= 1'b1;
            end
            expected <= expected + DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/axi_rd_master.sv
// axi_rd_master
// Splits a user read request of rd_len beats into AXI bursts of at most
// RBURST_LEN beats and streams the returned beats straight to the user side.
// Only one burst is outstanding at a time.
// Optional feature: define RD_CHECK_EN to build the rd_pattern_chk beat checker
// that drives rd_err; otherwise rd_err is tied low.
// Ports:
//   clk, rstn                         - clock, synchronous active-low reset
//   init_end                          - DDR2 init complete, gates rd_ready
//   axi_ar*                           - read address channel (master side)
//   axi_r*                            - read data channel (master side)
//   rd_trig/rd_len/rd_addr/rd_ready   - user request handshake
//   rd_data/rd_data_en                - delivered beats (zero latency)
//   rd_done                           - one-cycle completion pulse
//   rd_err                            - sticky pattern-check error
//
// state   | meaning
// IDLE    | waiting for a request; rd_ready follows init_end
// AR      | address phase, arvalid held until arready
// RD      | collecting beats until rlast
// DONE    | one-cycle rd_done pulse, then back to IDLE
module axi_rd_master
    import axi_rd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int RBURST_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init_end,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [AXI_LEN_W-1:0]  axi_arlen,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic                  axi_rlast,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  rd_trig,
    input  logic [AXI_LEN_W-1:0]  rd_len,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_en,
    output logic                  rd_done,
    output logic                  rd_err
);

    localparam logic [AXI_LEN_W:0] MAX_BEATS = (AXI_LEN_W + 1)'(RBURST_LEN);

    rd_state_t              state;
    logic [AXI_LEN_W-1:0]   remaining;
    logic [AXI_LEN_W:0]     burst_beats;
    logic [AXI_LEN_W-1:0]   rem_after;
    logic [ADDR_WIDTH-1:0]  addr_after;
    logic                   beat;

    // axi_araddr doubles as the running address; it is only advanced at rlast.
    assign burst_beats = {1'b0, axi_arlen} + 9'd1;
    assign rem_after   = remaining - AXI_LEN_W'(burst_beats);
    assign addr_after  = axi_araddr + ADDR_WIDTH'(burst_beats) * ADDR_WIDTH'(ADDR_STEP);
    assign beat        = axi_rvalid & axi_rready;

    assign rd_ready   = (state == ST_IDLE) && init_end;
    assign rd_data_en = beat;
    assign rd_data    = beat ? axi_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            axi_arvalid <= 1'b0;
            axi_araddr  <= '0;
            axi_arlen   <= '0;
            axi_rready  <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_trig && rd_ready) begin
                        axi_araddr <= rd_addr;
                        remaining  <= rd_len;
                        if (rd_len == '0) begin
                            state   <= ST_DONE;
                            rd_done <= 1'b1;
                        end else begin
                            state       <= ST_AR;
                            axi_arvalid <= 1'b1;
                            axi_arlen   <= calc_arlen(rd_len, MAX_BEATS);
                        end
                    end
                end
                ST_AR: begin
                    if (axi_arready) begin
                        state       <= ST_RD;
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (beat && axi_rlast) begin
                        axi_rready <= 1'b0;
                        axi_araddr <= addr_after;
                        remaining  <= rem_after;
                        if (rem_after != '0) begin
                            state       <= ST_AR;
                            axi_arvalid <= 1'b1;
                            axi_arlen   <= calc_arlen(rem_after, MAX_BEATS);
                        end else begin
                            state   <= ST_DONE;
                            rd_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    rd_done <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RD_CHECK_EN
    rd_pattern_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_pattern_chk (
        .clk     (clk),
        .rstn    (rstn),
        .data_en (rd_data_en),
        .data    (rd_data),
        .err     (rd_err)
    );
`else
    assign rd_err = 1'b0;
`endif

endmodule
